// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch and MDU handshake.
// Define PIPE_PERF_CNT_EN to build the load-use and MDU stall-cycle performance counters.
module pipeline_stall_ctrl #(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned TMO_W       = 7,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1D,
    input  logic [4:0]       RS2D,
    input  logic [4:0]       RDE,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MduOpE,
    input  logic             MduDone,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MduStart,
    output logic             MduTimeout,
    output logic [CNT_W-1:0] LoadUseCnt,
    output logic [CNT_W-1:0] MduCycleCnt
);

    typedef enum logic [0:0] {StRun, StMduBusy} state_e;

    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(MDU_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_flag_q, tmo_flag_d;
    logic             load_use;
    logic             stall_f, stall_d, stall_e;
    logic             flush_d, flush_e, flush_m;
    logic             mdu_start;

    assign load_use = LoadE & (RDE != 5'd0) & ((RDE == RS1D) | (RDE == RS2D));

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        tmo_flag_d = tmo_flag_q;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        mdu_start  = 1'b0;
        case (state_q)
            StRun: begin
                if (MduOpE) begin
                    // MDU launch swallows any concurrent load-use: everything is held anyway.
                    mdu_start = 1'b1;
                    stall_f   = 1'b1;
                    stall_d   = 1'b1;
                    stall_e   = 1'b1;
                    flush_m   = 1'b1;
                    tmo_d     = '0;
                    state_d   = StMduBusy;
                end else if (PCSrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            StMduBusy: begin
                if (MduDone) begin
                    state_d = StRun;
                end else if (tmo_q == TmoLast) begin
                    tmo_flag_d = 1'b1;
                    state_d    = StRun;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                    tmo_d   = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            tmo_q      <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    // Combinational controls are masked so that reset silences the pipeline immediately.
    always_comb begin
        StallF   = stall_f & ~rst;
        StallD   = stall_d & ~rst;
        StallE   = stall_e & ~rst;
        FlushD   = flush_d & ~rst;
        FlushE   = flush_e & ~rst;
        FlushM   = flush_m & ~rst;
        MduStart = mdu_start & ~rst;
    end

    assign MduTimeout = tmo_flag_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic             lu_evt;

    assign lu_evt = (state_q == StRun) & load_use & ~PCSrcE;

    always_comb begin
        lu_cnt_d  = lu_cnt_q + CNT_W'(lu_evt);
        mdu_cnt_d = mdu_cnt_q + CNT_W'(stall_e);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt_q  <= '0;
            mdu_cnt_q <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    assign LoadUseCnt  = lu_cnt_q;
    assign MduCycleCnt = mdu_cnt_q;
`else
    assign LoadUseCnt  = '0;
    assign MduCycleCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (MDU_TIMEOUT=8).
// Counter expectations follow PIPE_PERF_CNT_EN when the bench is built with the same define.
module tb_pipeline_stall_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam bit CntOn = 1'b1;
`else
    localparam bit CntOn = 1'b0;
`endif

    // Packed expected controls: {StallF, StallD, StallE, FlushD, FlushE, FlushM, MduStart}
    localparam logic [6:0] ONone   = 7'b0000000;
    localparam logic [6:0] OLdUse  = 7'b1100100;
    localparam logic [6:0] OBranch = 7'b0001100;
    localparam logic [6:0] OMduSt  = 7'b1110011;
    localparam logic [6:0] OMduBsy = 7'b1110010;

    logic        clk;
    logic        rst;
    logic [4:0]  RS1D, RS2D, RDE;
    logic        LoadE, PCSrcE, MduOpE, MduDone;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MduStart, MduTimeout;
    logic [31:0] LoadUseCnt, MduCycleCnt;
    logic [6:0]  outs;

    int n_chk  = 0;
    int n_fail = 0;
    int lu_exp = 0;

    pipeline_stall_ctrl #(
        .MDU_TIMEOUT(8),
        .TMO_W      (4),
        .CNT_W      (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RS1D       (RS1D),
        .RS2D       (RS2D),
        .RDE        (RDE),
        .LoadE      (LoadE),
        .PCSrcE     (PCSrcE),
        .MduOpE     (MduOpE),
        .MduDone    (MduDone),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .MduStart   (MduStart),
        .MduTimeout (MduTimeout),
        .LoadUseCnt (LoadUseCnt),
        .MduCycleCnt(MduCycleCnt)
    );

    assign outs = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MduStart};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) assert (!(MduOpE && PCSrcE)) else $error("MduOpE and PCSrcE both high");
    end

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rde;
        logic       load, pc, op, done;
        logic [6:0] exp;
        int         lu_inc;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(input string n, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rde, input logic load, input logic pc,
                                input logic done, input logic [6:0] exp, input int lu_inc);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.rde = rde;
        v.load = load; v.pc = pc; v.op = 1'b0; v.done = done;
        v.exp = exp; v.lu_inc = lu_inc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rde,
                          input logic load, input logic pc, input logic op, input logic done);
        RS1D = rs1; RS2D = rs2; RDE = rde;
        LoadE = load; PCSrcE = pc; MduOpE = op; MduDone = done;
    endtask

    // Drive one cycle at the falling edge, check controls mid-low-phase, then pass the rising edge.
    task automatic step(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rde, input logic load, input logic pc, input logic op,
                        input logic done, input logic [6:0] exp);
        @(negedge clk);
        set_in(rs1, rs2, rde, load, pc, op, done);
        #2;
        check(name, {25'd0, outs}, {25'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        tbl[0] = mk("idle",           5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ONone,   0);
        tbl[1] = mk("loaduse_rs1",    5'd5, 5'd9, 5'd5, 1'b1, 1'b0, 1'b0, OLdUse,  1);
        tbl[2] = mk("loaduse_rs2",    5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, OLdUse,  1);
        tbl[3] = mk("load_rd_zero",   5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, ONone,   0);
        tbl[4] = mk("load_nomatch",   5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, ONone,   0);
        tbl[5] = mk("match_noload",   5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, ONone,   0);
        tbl[6] = mk("branch_loaduse", 5'd0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, OBranch, 0);
        tbl[7] = mk("branch_only",    5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, OBranch, 0);
        tbl[8] = mk("spurious_done",  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ONone,   0);

        // Reset with a live load-use pattern: everything must read 0.
        rst = 1'b1;
        set_in(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        check("reset_outs", {25'd0, outs}, 32'd0);
        check("reset_tmo", {31'd0, MduTimeout}, 32'd0);
        check("reset_lucnt", LoadUseCnt, 32'd0);
        check("reset_mducnt", MduCycleCnt, 32'd0);
        @(negedge clk);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].name, tbl[i].rs1, tbl[i].rs2, tbl[i].rde, tbl[i].load, tbl[i].pc,
                 tbl[i].op, tbl[i].done, tbl[i].exp);
            lu_exp += tbl[i].lu_inc;
            check({tbl[i].name, "_lucnt"}, LoadUseCnt, CntOn ? lu_exp : 0);
        end

        // MDU normal: 4 busy cycles then done; load-use inputs in busy are ignored.
        step("mdu_start", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, OMduSt);
        for (int i = 0; i < 4; i++)
            step("mdu_busy", 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, OMduBsy);
        step("mdu_done", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, ONone);
        check("mdu_cnt_normal", MduCycleCnt, CntOn ? 32'd5 : 32'd0);
        check("mdu_tmo_clear", {31'd0, MduTimeout}, 32'd0);
        step("run_after_mdu", 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, OLdUse);
        lu_exp++;
        check("lucnt_after_mdu", LoadUseCnt, CntOn ? lu_exp : 0);

        // MDU timeout: 1 start + 7 busy stall cycles, release on the 8th busy cycle.
        step("tmo_start", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, OMduSt);
        for (int i = 0; i < 7; i++)
            step("tmo_busy", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, OMduBsy);
        check("tmo_not_yet", {31'd0, MduTimeout}, 32'd0);
        step("tmo_release", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ONone);
        check("tmo_set", {31'd0, MduTimeout}, 32'd1);
        check("mdu_cnt_tmo", MduCycleCnt, CntOn ? 32'd13 : 32'd0);

        // Following op with concurrent load-use: absorbed, flag stays sticky.
        step("op3_start_lu", 5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, OMduSt);
        step("op3_done", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, ONone);
        check("tmo_sticky", {31'd0, MduTimeout}, 32'd1);
        check("mdu_cnt_op3", MduCycleCnt, CntOn ? 32'd14 : 32'd0);
        step("idle_post", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ONone);
        check("tmo_sticky2", {31'd0, MduTimeout}, 32'd1);

        // Reset asserted asynchronously during the 2nd busy cycle.
        step("rst_op_start", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, OMduSt);
        step("rst_busy1", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, OMduBsy);
        @(negedge clk);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        check("rst_busy2", {25'd0, outs}, {25'd0, OMduBsy});
        rst = 1'b1;
        #1;
        check("rst_async_outs", {25'd0, outs}, 32'd0);
        check("rst_async_tmo", {31'd0, MduTimeout}, 32'd0);
        check("rst_async_mducnt", MduCycleCnt, 32'd0);
        check("rst_async_lucnt", LoadUseCnt, 32'd0);
        @(negedge clk);
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("stray_done_outs", {25'd0, outs}, 32'd0);
        @(posedge clk);
        #1;
        step("run_after_rst", 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, OLdUse);
        check("lucnt_after_rst", LoadUseCnt, CntOn ? 32'd1 : 32'd0);
        check("mducnt_after_rst", MduCycleCnt, 32'd0);
        check("tmo_after_rst", {31'd0, MduTimeout}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Sequencing controller for the 5-stage pipeline, complementing the EX-stage forwarding logic.
- Generates stall and flush controls for the IF, ID, EX and MEM stage registers.
- Covers three cases that forwarding cannot resolve: load-use hazards, taken branches and jumps, and multi-cycle multiply/divide (MDU) operations.
- Owns the MDU start/done handshake and a timeout watchdog.

Parameters:
MDU_TIMEOUT, 64, max cycles in MDU_BUSY before forced abort (must be >= 2)
TMO_W, 7, width of timeout counter (must hold MDU_TIMEOUT)
CNT_W, 32, width of optional performance counters

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
RS1D  input  5  rs1 of instruction in ID
RS2D  input  5  rs2 of instruction in ID
RDE  input  5  rd of instruction in EX
LoadE  input  1  EX instruction is a load
PCSrcE  input  1  taken branch/jump resolved in EX
MduOpE  input  1  EX instruction is a mul/div op
MduDone  input  1  MDU result valid (single-cycle pulse)
StallF  output  1  hold PC register
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear ID/EX register
FlushM  output  1  clear EX/MEM register (bubble)
MduStart  output  1  one-cycle MDU launch pulse
MduTimeout  output  1  sticky watchdog error flag
LoadUseCnt  output  CNT_W  load-use stall cycles (optional feature)
MduCycleCnt  output  CNT_W  MDU stall cycles (optional feature)

Behaviour:
Reset and clocking:
- One clock, clk. Reset rst is asynchronous and active-high.
- While rst=1: state=RUN, timeout counter=0, MduTimeout=0, counters=0, and every output is forced to 0, combinational ones included.

FSM states: RUN, MDU_BUSY.

RUN:
- loaduse = LoadE & (RDE!=0) & ((RDE==RS1D) | (RDE==RS2D)).
- PCSrcE=1: FlushD=1 and FlushE=1. No stalls. Branch has priority over load-use.
- loaduse=1 with PCSrcE=0: StallF=1, StallD=1, FlushE=1 for that cycle, giving exactly one bubble.
- MduOpE=1:
  - MduStart=1 for this cycle only.
  - Next state MDU_BUSY, timeout counter cleared.
  - Stall outputs in this cycle: StallF=StallD=StallE=1, FlushM=1.
  - A concurrent loaduse is absorbed (no FlushE).
- MduOpE and PCSrcE are mutually exclusive; the bench asserts this.

MDU_BUSY:
- StallF=StallD=StallE=1 and FlushM=1 every cycle while MduDone=0.
- Timeout counter increments each cycle.
- loaduse and PCSrcE are ignored, because the ID/EX contents are frozen.
- MduDone=1: all stalls and FlushM deassert in the same cycle, EX advances and the result is captured. Next state RUN, with no MduStart re-issue.
- Counter reaches MDU_TIMEOUT-1 with MduDone=0: MduTimeout sets and stays set until reset. Stalls release that cycle; next state RUN.
- MduDone=1 in RUN is ignored.

Latency and cost:
- Load-use costs exactly 1 cycle.
- A taken branch costs 2 squashed instructions.
- An MDU op costs N+1 stall cycles when MduDone arrives N cycles after MduStart.
- No outputs are registered except the FSM state, the counters and MduTimeout. Stalls and flushes are combinational from inputs and state.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined:
  - LoadUseCnt increments on each RUN cycle with loaduse=1 and PCSrcE=0.
  - MduCycleCnt increments on each cycle where StallE=1 due to MDU (includes the MduStart cycle).
  - Both counters wrap modulo 2^CNT_W and clear on reset.
- Not defined: both ports are driven constant 0 and no counter flops are synthesized.

Test Plan:
- Load-use: LoadE=1, RDE=5, RS1D=5 for one cycle -> StallF=StallD=FlushE=1 that cycle only, with LoadUseCnt=1 when the macro is on. Repeat with RDE=0 -> no stall.
- Taken branch with load-use: PCSrcE=1, LoadE=1, RDE=3, RS2D=3 -> FlushD=FlushE=1, StallF=StallD=0.
- MDU normal: MduOpE=1, MduDone arrives 4 cycles after MduStart -> MduStart high 1 cycle, StallE high 5 cycles, FlushM high 5 cycles, state back to RUN, MduCycleCnt=5.
- MDU timeout: MDU_TIMEOUT=8, MduDone never asserted -> stalls release after 8 total stall cycles, MduTimeout=1 and stays 1 through subsequent ops.
- Reset mid-operation: assert rst during the 2nd MDU_BUSY cycle, asynchronously off a clock edge -> all outputs 0 immediately. After release: state RUN, counters 0, and a stray MduDone is ignored.
- Spurious done: MduDone=1 in RUN with no op pending -> no output change.
